// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: response-owner encoding,
// starvation limit default and the shared-port request bundle.
package sram_arb_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int ADDR_W               = 32;
    localparam int DATA_W               = 32;
    localparam int WEN_W                = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    typedef struct packed {
        logic              en;
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Issue a request bundle for one requester's fields.
    function automatic mem_req_t mem_req_issue(
        input logic [WEN_W-1:0]  wen,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        mem_req_t r;
        r.en    = 1'b1;
        r.wen   = wen;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive data grants taken while inst waits and raises force_inst
// once inst has waited STARVE_LIMIT data grants.
module arb_starve_cnt
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_wait,
    input  logic data_won,
    input  logic inst_won,
    output logic force_inst
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_q;
    logic [2:0] starve_cnt_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (inst_won || !inst_wait) begin
            starve_cnt_d = 3'd0;
        end else if (data_won && starve_cnt_q != 3'd7) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 3'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_inst = inst_wait && (starve_cnt_q == LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (inst/data) arbiter for a single-port SRAM with one-cycle
// read latency: combinational grant, registered response owner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [3:0]  inst_wen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,

    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        stallreq
);

    owner_e   owner_q;
    owner_e   owner_d;
    mem_req_t mem_req;
    logic     force_inst;
    logic     inst_gnt_c;
    logic     data_gnt_c;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inst_wait  (inst_req),
        .data_won   (data_gnt_c),
        .inst_won   (inst_gnt_c),
        .force_inst (force_inst)
    );

    // Data wins by default; a starved inst takes the port when both compete.
    always_comb begin
        data_gnt_c = 1'b0;
        inst_gnt_c = 1'b0;
        if (!rst) begin
            data_gnt_c = data_req && !(inst_req && force_inst);
            inst_gnt_c = inst_req && !data_gnt_c;
        end
    end

    always_comb begin
        mem_req = '0;
        owner_d = OWNER_NONE;
        if (inst_gnt_c) begin
            mem_req = mem_req_issue(inst_wen, inst_addr, inst_wdata);
            owner_d = OWNER_INST;
        end else if (data_gnt_c) begin
            mem_req = mem_req_issue(data_wen, data_addr, data_wdata);
            owner_d = OWNER_DATA;
        end
    end

    // Async reset clears the owner at once, dropping any response in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        inst_rvalid = (owner_q == OWNER_INST);
        data_rvalid = (owner_q == OWNER_DATA);
        inst_rdata  = inst_rvalid ? mem_rdata : 32'd0;
        data_rdata  = data_rvalid ? mem_rdata : 32'd0;
    end

    assign inst_gnt  = inst_gnt_c;
    assign data_gnt  = data_gnt_c;
    assign mem_en    = mem_req.en;
    assign mem_wen   = mem_req.wen;
    assign mem_addr  = mem_req.addr;
    assign mem_wdata = mem_req.wdata;
    assign stallreq  = !rst && ((inst_req && !inst_gnt_c) || (data_req && !data_gnt_c));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with STARVE_LIMIT = 4.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req;
    logic [3:0]  inst_wen, data_wen;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stallreq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stallreq(stallreq)
    );

    task automatic clear_inputs();
        inst_req = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        mem_rdata = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        inst_req = 1; data_req = 1; data_wen = 4'hF; data_addr = 32'h55; data_wdata = 32'h77;
        mem_rdata = 32'hFFFF_FFFF;
        next_cycle();
        n_cmp++; if (inst_gnt !== 1'b0) begin n_bad++; $display("FAIL reset.inst_gnt got %b want 0", inst_gnt); end
        n_cmp++; if (data_gnt !== 1'b0) begin n_bad++; $display("FAIL reset.data_gnt got %b want 0", data_gnt); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL reset.mem_en got %b want 0", mem_en); end
        n_cmp++; if ({mem_wen, mem_addr, mem_wdata} !== 68'd0) begin n_bad++; $display("FAIL reset.mem_bus got %h/%h/%h want 0", mem_wen, mem_addr, mem_wdata); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL reset.stallreq got %b want 0", stallreq); end
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_bad++; $display("FAIL reset.rvalid got %b want 00", {inst_rvalid, data_rvalid}); end
        n_cmp++; if ({inst_rdata, data_rdata} !== 64'd0) begin n_bad++; $display("FAIL reset.rdata got %h/%h want 0", inst_rdata, data_rdata); end
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_bad++; $display("FAIL reset.post_rvalid got %b want 00", {inst_rvalid, data_rvalid}); end
    endtask

    task automatic test_idle();
        clear_inputs();
        #1;
        n_cmp++; if ({inst_gnt, data_gnt, stallreq, mem_en} !== 4'b0000) begin n_bad++; $display("FAIL idle.ctrl got %b want 0000", {inst_gnt, data_gnt, stallreq, mem_en}); end
        n_cmp++; if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL idle.mem_addr got %h want 0", mem_addr); end
        next_cycle();
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_bad++; $display("FAIL idle.rvalid got %b want 00", {inst_rvalid, data_rvalid}); end
    endtask

    task automatic test_inst_read();
        clear_inputs();
        inst_req = 1; inst_addr = 32'h1FC0_0000;
        #1;
        n_cmp++; if ({inst_gnt, data_gnt} !== 2'b10) begin n_bad++; $display("FAIL inst_read.gnt got %b want 10", {inst_gnt, data_gnt}); end
        n_cmp++; if (mem_en !== 1'b1 || mem_wen !== 4'h0) begin n_bad++; $display("FAIL inst_read.mem_en got %b/%h want 1/0", mem_en, mem_wen); end
        n_cmp++; if (mem_addr !== 32'h1FC0_0000) begin n_bad++; $display("FAIL inst_read.mem_addr got %h want 1fc00000", mem_addr); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL inst_read.stall0 got %b want 0", stallreq); end
        next_cycle();
        inst_req = 0; mem_rdata = 32'h1234_5678;
        #1;
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b10) begin n_bad++; $display("FAIL inst_read.rvalid got %b want 10", {inst_rvalid, data_rvalid}); end
        n_cmp++; if (inst_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL inst_read.rdata got %h want 12345678", inst_rdata); end
        n_cmp++; if (data_rdata !== 32'd0) begin n_bad++; $display("FAIL inst_read.other_rdata got %h want 0", data_rdata); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL inst_read.stall1 got %b want 0", stallreq); end
        next_cycle();
        n_cmp++; if (inst_rvalid !== 1'b0) begin n_bad++; $display("FAIL inst_read.rvalid_once got %b want 0", inst_rvalid); end
    endtask

    task automatic test_conflict();
        clear_inputs();
        inst_req = 1; inst_addr = 32'h200;
        data_req = 1; data_addr = 32'h100;
        #1;
        n_cmp++; if ({inst_gnt, data_gnt} !== 2'b01) begin n_bad++; $display("FAIL conflict.gnt0 got %b want 01", {inst_gnt, data_gnt}); end
        n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL conflict.stall0 got %b want 1", stallreq); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL conflict.addr0 got %h want 100", mem_addr); end
        next_cycle();
        data_req = 0; mem_rdata = 32'hA5A5_0001;
        #1;
        n_cmp++; if ({inst_gnt, data_gnt} !== 2'b10) begin n_bad++; $display("FAIL conflict.gnt1 got %b want 10", {inst_gnt, data_gnt}); end
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b01) begin n_bad++; $display("FAIL conflict.rvalid1 got %b want 01", {inst_rvalid, data_rvalid}); end
        n_cmp++; if (data_rdata !== 32'hA5A5_0001 || inst_rdata !== 32'd0) begin n_bad++; $display("FAIL conflict.rdata1 got %h/%h want a5a50001/0", data_rdata, inst_rdata); end
        n_cmp++; if (mem_addr !== 32'h200 || stallreq !== 1'b0) begin n_bad++; $display("FAIL conflict.addr1 got %h/%b want 200/0", mem_addr, stallreq); end
        next_cycle();
        inst_req = 0; mem_rdata = 32'hA5A5_0002;
        #1;
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b10 || inst_rdata !== 32'hA5A5_0002) begin n_bad++; $display("FAIL conflict.rvalid2 got %b/%h want 10/a5a50002", {inst_rvalid, data_rvalid}, inst_rdata); end
        next_cycle();
    endtask

    // Limit 4: data takes cycles 0-3, inst cycle 4, then the count restarts.
    task automatic test_starvation();
        logic exp_inst, prev_data;
        clear_inputs();
        inst_req = 1; data_req = 1;
        prev_data = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_inst = (k == 4) || (k == 9);
            #1;
            n_cmp++; if ({inst_gnt, data_gnt} !== {exp_inst, ~exp_inst}) begin n_bad++; $display("FAIL starve.gnt[%0d] got %b want %b", k, {inst_gnt, data_gnt}, {exp_inst, ~exp_inst}); end
            n_cmp++; if (data_rvalid !== prev_data) begin n_bad++; $display("FAIL starve.data_rvalid[%0d] got %b want %b", k, data_rvalid, prev_data); end
            prev_data = ~exp_inst;
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_write();
        clear_inputs();
        data_req = 1; data_wen = 4'b0011; data_addr = 32'h40; data_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (data_gnt !== 1'b1 || mem_en !== 1'b1) begin n_bad++; $display("FAIL write.gnt got %b/%b want 1/1", data_gnt, mem_en); end
        n_cmp++; if (mem_wen !== 4'b0011) begin n_bad++; $display("FAIL write.wen got %b want 0011", mem_wen); end
        n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h40) begin n_bad++; $display("FAIL write.wdata got %h@%h want deadbeef@40", mem_wdata, mem_addr); end
        next_cycle();
        data_req = 0; data_wen = 0;
        #1;
        n_cmp++; if (data_rvalid !== 1'b1) begin n_bad++; $display("FAIL write.rvalid got %b want 1", data_rvalid); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        data_req = 1; data_addr = 32'h80;
        next_cycle();
        data_req = 0; mem_rdata = 32'h0BAD_F00D;
        #1;
        n_cmp++; if (data_rvalid !== 1'b1) begin n_bad++; $display("FAIL rst_mid.pre_rvalid got %b want 1", data_rvalid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (data_rvalid !== 1'b0 || data_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_mid.drop got %b/%h want 0/0", data_rvalid, data_rdata); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        n_cmp++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_mid.after got %b want 00", {inst_rvalid, data_rvalid}); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        inst_req = 1; inst_addr = 32'h0;
        #1;
        n_cmp++; if (inst_gnt !== 1'b1 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL b2b.gnt0 got %b@%h want 1@0", inst_gnt, mem_addr); end
        next_cycle();
        inst_addr = 32'h4; mem_rdata = 32'h1111_0000;
        #1;
        n_cmp++; if (inst_gnt !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL b2b.gnt1 got %b@%h want 1@4", inst_gnt, mem_addr); end
        n_cmp++; if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h1111_0000) begin n_bad++; $display("FAIL b2b.resp0 got %b/%h want 1/11110000", inst_rvalid, inst_rdata); end
        next_cycle();
        inst_req = 0; mem_rdata = 32'h2222_0004;
        #1;
        n_cmp++; if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h2222_0004) begin n_bad++; $display("FAIL b2b.resp1 got %b/%h want 1/22220004", inst_rvalid, inst_rdata); end
        n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL b2b.stall got %b want 0", stallreq); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_inst_read();
        test_conflict();
        test_starvation();
        test_write();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
